// File: rtl/overlay_bitmap_loader.sv
// Runtime-loadable 22x9-cell overlay bitmap: streamed into a shadow copy,
// swapped into the display copy at frame start, looked up from beam position.
module overlay_bitmap_loader #(
  parameter int          COLS     = 22,
  parameter int          ROWS     = 9,
  parameter int          ORIGIN_X = 30,
  parameter int          ORIGIN_Y = 25,
  parameter logic [7:0]  HEADER   = 8'hA5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       frame_start,
  input  logic [9:0] x,
  input  logic [9:0] y,
  output logic       overlay_active,
  output logic       busy,
  output logic       load_done
);

  localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_LOAD    = 2'd1;
  localparam logic [1:0] S_PENDING = 2'd2;

  logic [1:0]       state;
  logic [ROW_W-1:0] row_idx;
  logic [1:0]       byte_idx;
  logic [23:0]      shadow  [ROWS];
  logic [23:0]      display [ROWS];

  logic accept;
  logic last_byte;
  logic swap;

  assign in_ready  = (state != S_PENDING);
  assign busy      = (state == S_LOAD) || (state == S_PENDING);
  assign accept    = in_valid && in_ready;
  assign last_byte = (row_idx == ROW_W'(ROWS - 1)) && (byte_idx == 2'd2);
  assign swap      = (state == S_PENDING) && frame_start;

  // Row/byte counters replace a flat byte counter so no divide-by-3 is needed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      row_idx   <= '0;
      byte_idx  <= '0;
      load_done <= 1'b0;
    end else begin
      load_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept && (in_data == HEADER)) begin
            state    <= S_LOAD;
            row_idx  <= '0;
            byte_idx <= '0;
          end
        end
        S_LOAD: begin
          if (accept) begin
            if (last_byte) begin
              state <= S_PENDING;
            end else if (byte_idx == 2'd2) begin
              byte_idx <= '0;
              row_idx  <= row_idx + 1'b1;
            end else begin
              byte_idx <= byte_idx + 1'b1;
            end
          end
        end
        S_PENDING: begin
          if (frame_start) begin
            state     <= S_IDLE;
            load_done <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < ROWS; r++) shadow[r] <= '0;
    end else if ((state == S_LOAD) && accept) begin
      case (byte_idx)
        2'd0:    shadow[row_idx][7:0]   <= in_data;
        2'd1:    shadow[row_idx][15:8]  <= in_data;
        default: shadow[row_idx][23:16] <= in_data;
      endcase
    end
  end

  // Whole-bitmap copy in one edge, so the visible image never mixes loads.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < ROWS; r++) display[r] <= '0;
    end else if (swap) begin
      for (int r = 0; r < ROWS; r++) display[r] <= shadow[r];
    end
  end

  logic [6:0] off_x;
  logic [6:0] off_y;
  logic       hit;
  logic       unused_low_bits;

  assign off_x           = x[9:3] - 7'(ORIGIN_X);
  assign off_y           = y[9:3] - 7'(ORIGIN_Y);
  assign unused_low_bits = ^{x[2:0], y[2:0]};

  // Positions before the origin wrap to large offsets and fail the range test.
  always_comb begin
    hit = 1'b0;
    if ((off_x < 7'(COLS)) && (off_y < 7'(ROWS))) begin
      hit = display[off_y[ROW_W-1:0]][off_x[4:0]];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) overlay_active <= 1'b0;
    else     overlay_active <= hit;
  end

endmodule

// File: doc/overlay_bitmap_loader.md
# overlay_bitmap_loader

Runtime-programmable 22×9-cell overlay bitmap for the VGA demo path. It accepts a byte stream over a valid/ready interface into a shadow buffer and swaps that buffer into the display copy only at a frame boundary, so a load never tears. From the beam position it produces a registered `overlay_active` pixel flag. It is the writable counterpart to the fixed-bitmap text overlays and sits between the host/config input and the pixel mixer.

## Interface
- `COLS`, 22: bitmap width in 8-pixel cells (max 24).
- `ROWS`, 9: bitmap height in 8-pixel cells.
- `ORIGIN_X`, 30: left edge in cells (x[9:3] units).
- `ORIGIN_Y`, 25: top edge in cells (y[9:3] units).
- `HEADER`, 8'hA5: start-of-load marker byte.

Ports:
- `clk`  in  1  pixel clock.
- `rst`  in  1  asynchronous, active-high reset.
- `in_data`  in  8  load byte.
- `in_valid`  in  1  `in_data` valid.
- `in_ready`  out  1  byte accepted when `in_valid & in_ready`.
- `frame_start`  in  1  one-cycle pulse at the start of vertical blanking.
- `x`, `y`  in  10 each  current beam position.
- `overlay_active`  out  1  registered overlay pixel flag.
- `busy`  out  1  load in progress or swap pending.
- `load_done`  out  1  one-cycle pulse when the swap happens.

## Operation
- Storage: two arrays of ROWS×24 bits, `shadow` and `display`.
  - Reset clears both to 0.
  - All outputs reset to 0, except `in_ready`, which resets to 1.
- Stream format: `HEADER`, then ROWS×3 data bytes (27 by default), row-major from row 0.
  - Byte k of a row (k = 0..2) bit b maps to column 8k+b.
  - Columns ≥ COLS are stored but never displayed.
- FSM:
  - IDLE: `in_ready`=1. An accepted byte equal to `HEADER` → LOAD, with byte counter cleared. Any other accepted byte is discarded.
  - LOAD: `in_ready`=1. Each accepted byte is written into `shadow` at the counter position and the counter increments. A `HEADER` value is treated as data here. When the accepted byte is the last (counter = ROWS×3−1) → PENDING.
  - PENDING: `in_ready`=0. On `frame_start`, `display` ← `shadow` in one cycle, `load_done` pulses the following cycle, → IDLE.
- `busy` = state is LOAD or PENDING.
- `frame_start` in IDLE or LOAD is ignored; `display` is unchanged.
- `frame_start` in the same cycle as the last byte is accepted does not swap. The FSM enters PENDING and waits for the next `frame_start`.
- Lookup, with 7-bit modular subtraction:
  - off_x = x[9:3] − ORIGIN_X
  - off_y = y[9:3] − ORIGIN_Y
  - The pixel is active iff off_x < COLS, off_y < ROWS, and display[off_y][off_x] = 1.
  - Positions left of or above the origin wrap to large offsets and read 0.
- Reset mid-load: the FSM returns to IDLE, the partial load is lost, and both buffers are cleared.

## Timing
- `overlay_active` has exactly 1 cycle of latency from `x`/`y`.
- The swap takes effect on the edge that samples `frame_start` in PENDING. Lookups from the next cycle use the new `display`.
- `load_done` is high for exactly 1 cycle, one cycle after the swap edge.
- Throughput: one byte per cycle in IDLE and LOAD. A full load takes 28 accepted cycles minimum.
- `in_ready` is a function of state only. It does not depend combinationally on `in_valid`.

## Test plan
- Reset: assert `rst` asynchronously mid-cycle → `overlay_active`=0, `busy`=0, `load_done`=0, `in_ready`=1 immediately. Sweep the full frame → `overlay_active` stays 0.
- All-ones load: send A5 then 27×FF, then pulse `frame_start`.
  - x=240, y=200 → `overlay_active`=1 one cycle later.
  - x=408, y=264 → 1.
  - x=416, y=200 → 0.
  - x=232, y=200 → 0.
  - y=272 → 0.
  - `load_done` pulses once.
- Checkerboard (rows alternating 55 55 15 / AA AA 2A) with bit mapping check: (cell 30, row 0)=1, (31, 0)=0, (30, 1)=0, (51, 1)=1.
- No tearing: after the 27th byte, `busy`=1, `in_ready`=0, and display remains old for 1000 cycles. Only after `frame_start` does the new data appear.
- Framing: leading bytes 00, 7F are discarded. `frame_start` pulsed during LOAD causes no swap. `frame_start` coincident with the last byte causes no swap; the next `frame_start` swaps.
- Reset mid-load after 10 bytes → IDLE, display all 0. A subsequent full load works.
